// File: rtl/serial_gate_responder.sv
// serial_gate_responder
// Receives a framed serial command (2-bit opcode, operand A, operand B; all
// MSB first). It evaluates AND / OR / NOT on the operands and holds the W-bit
// result on a valid/ready output until the consumer takes it.
module serial_gate_responder #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic         in_bit,
    output logic         in_ready,
    input  logic         in_clear,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_err
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_OP   = 2'd0,
        S_A    = 2'd1,
        S_B    = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_op;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [W-1:0]    r_out_data;
    logic            r_out_err;

    logic            w_accept;
    logic            w_last_field_bit;
    logic [W-1:0]    w_b_next;

    // Gate evaluation; the reserved opcode yields zero data.
    function automatic logic [W-1:0] f_eval(input logic [1:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [W-1:0] res;
        case (op)
            2'b00:   res = a & b;
            2'b01:   res = a | b;
            2'b10:   res = ~a;
            default: res = '0;
        endcase
        return res;
    endfunction

    assign w_accept         = in_valid & r_in_ready & ~in_clear;
    assign w_last_field_bit = (r_cnt == CW'(W - 1));
    // Final B value including the bit arriving this cycle, so the result can
    // be registered on the same edge that completes the frame.
    assign w_b_next         = {r_b[W-2:0], in_bit};

    // Frame reception FSM with registered handshake outputs and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_OP;
            r_cnt       <= '0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
        end else begin
            case (r_state)
                S_OP, S_A, S_B: begin
                    if (in_clear) begin
                        // Abort wins over a simultaneous bit; partial fields are dropped.
                        r_state <= S_OP;
                        r_cnt   <= '0;
                    end else if (w_accept) begin
                        case (r_state)
                            S_OP: begin
                                r_op <= {r_op[0], in_bit};
                                if (r_cnt == CW'(1)) begin
                                    r_state <= S_A;
                                    r_cnt   <= '0;
                                end else begin
                                    r_cnt <= r_cnt + CW'(1);
                                end
                            end
                            S_A: begin
                                r_a <= {r_a[W-2:0], in_bit};
                                if (w_last_field_bit) begin
                                    r_state <= S_B;
                                    r_cnt   <= '0;
                                end else begin
                                    r_cnt <= r_cnt + CW'(1);
                                end
                            end
                            default: begin
                                r_b <= w_b_next;
                                if (w_last_field_bit) begin
                                    r_state     <= S_RESP;
                                    r_cnt       <= '0;
                                    r_in_ready  <= 1'b0;
                                    r_out_valid <= 1'b1;
                                    r_out_data  <= f_eval(r_op, r_a, w_b_next);
                                    r_out_err   <= (r_op == 2'b11);
                                end else begin
                                    r_cnt <= r_cnt + CW'(1);
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    // Result is held until taken; out_data/out_err keep their values.
                    if (out_ready) begin
                        r_state     <= S_OP;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_err   = r_out_err;

endmodule
